// File: rtl/game_io_pkg.sv
// Shared constants and helpers for the game I/O front end.
// Sync polarities are the standard VESA levels for the common modes.
package game_io_pkg;

  localparam int DEB_CYCLES_DEFAULT = 65536;

  localparam bit VGA640_HSYNC_POL  = 1'b0;
  localparam bit VGA640_VSYNC_POL  = 1'b0;
  localparam bit SVGA800_HSYNC_POL = 1'b1;
  localparam bit SVGA800_VSYNC_POL = 1'b1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_io_frontend_key_debounce.sv
// One key channel: two-flop synchroniser, counting debouncer, press detect.
// level_o/press_o move DEB_CYCLES+1 edges after the raw change is first sampled.
module key_debounce
  import game_io_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_CYCLES_DEFAULT,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          s_q, s_d;
  logic          press_q, press_d;
  logic [CW-1:0] c_q, c_d;
  logic          sample;

  assign sample = sync2_q ^ KEY_ACTIVE_LOW;

  always_comb begin
    sync1_d = key_raw_i;
    sync2_d = sync1_q;
    s_d     = s_q;
    c_d     = c_q;
    press_d = 1'b0;
    if (sample == s_q) begin
      c_d = '0;
    end else if (c_q == C_LAST) begin
      s_d     = ~s_q;
      c_d     = '0;
      press_d = ~s_q;
    end else begin
      c_d = c_q + 1'b1;
    end
  end

  // Sync flops idle at the raw inactive level so reset never looks like a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= KEY_ACTIVE_LOW;
      sync2_q <= KEY_ACTIVE_LOW;
      s_q     <= 1'b0;
      c_q     <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s_q     <= s_d;
      c_q     <= c_d;
      press_q <= press_d;
    end
  end

  assign level_o = s_q;
  assign press_o = press_q;

endmodule

// File: rtl/game_io_frontend.sv
// Board-to-game-core front end: pixel clock enable, debounced keys,
// and per-frame key latching on the leading edge of vsync.
module game_io_frontend
  import game_io_pkg::*;
#(
  parameter int DIV            = 2,
  parameter int N_KEYS         = 4,
  parameter int DEB_CYCLES     = DEB_CYCLES_DEFAULT,
  parameter bit KEY_ACTIVE_LOW = 1'b0,
  parameter bit VSYNC_POL      = VGA640_VSYNC_POL
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] keys_i,
  input  logic              vsync_i,
  output logic              pix_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_frame,
  output logic              frame_tick
);

  localparam int DW = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0]     div_q, div_d;
  logic              pix_en_q, pix_en_d;
  logic              vq_q, vq_d;
  logic              frame_tick_q, frame_tick_d;
  logic [N_KEYS-1:0] key_frame_q, key_frame_d;
  logic [N_KEYS-1:0] sticky_q, sticky_d;
  logic              frame_start;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_key (
      .clk      (clk),
      .resetn   (resetn),
      .key_raw_i(keys_i[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i])
    );
  end

  assign frame_start = (vsync_i == VSYNC_POL) && (vq_q != VSYNC_POL);

  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d     = (div_q == DIV_LAST);
    vq_d         = vsync_i;
    frame_tick_d = frame_start;
    key_frame_d  = key_frame_q;
    sticky_d     = sticky_q | key_press;
    // Sticky holds taps that were released before the frame edge arrived.
    if (frame_start) begin
      key_frame_d = key_level | sticky_q;
      sticky_d    = key_press;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q        <= '0;
      pix_en_q     <= 1'b0;
      vq_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      key_frame_q  <= '0;
      sticky_q     <= '0;
    end else begin
      div_q        <= div_d;
      pix_en_q     <= pix_en_d;
      vq_q         <= vq_d;
      frame_tick_q <= frame_tick_d;
      key_frame_q  <= key_frame_d;
      sticky_q     <= sticky_d;
    end
  end

  assign pix_en     = pix_en_q;
  assign frame_tick = frame_tick_q;
  assign key_frame  = key_frame_q;

endmodule

// File: tb/tb_game_io_frontend.sv
// Bench for game_io_frontend: directed scenarios plus randomized keys/vsync
// checked against a window-based reference model of the front end.
module tb_game_io_frontend;

  localparam int DIV_A = 3;
  localparam int NK    = 4;
  localparam int DEB   = 4;

  logic          clk = 1'b0;
  logic          rstn_a, rstn_b;
  logic          vs_a, vs_b;
  logic [NK-1:0] keys_a, keys_b;
  logic          pix_a, pix_b, tick_a, tick_b;
  logic [NK-1:0] lvl_a, prs_a, kf_a, lvl_b, prs_b, kf_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  game_io_frontend #(
    .DIV(DIV_A), .N_KEYS(NK), .DEB_CYCLES(DEB), .KEY_ACTIVE_LOW(1'b0), .VSYNC_POL(1'b0)
  ) u_dut_a (
    .clk(clk), .resetn(rstn_a), .keys_i(keys_a), .vsync_i(vs_a),
    .pix_en(pix_a), .key_level(lvl_a), .key_press(prs_a), .key_frame(kf_a), .frame_tick(tick_a)
  );

  game_io_frontend #(
    .DIV(1), .N_KEYS(NK), .DEB_CYCLES(DEB), .KEY_ACTIVE_LOW(1'b1), .VSYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .resetn(rstn_b), .keys_i(keys_b), .vsync_i(vs_b),
    .pix_en(pix_b), .key_level(lvl_b), .key_press(prs_b), .key_frame(kf_b), .frame_tick(tick_b)
  );

  // Reference model for DUT A. A key level flips once the last DEB synced
  // samples all disagree with it; frame logic follows the vsync-edge rules.
  int            m_edges;
  logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_sticky, m_kf;
  logic          m_tick, m_vprev, m_pix;
  logic [NK-1:0] m_hist[$];

  initial begin
    logic [NK-1:0] seen, np;
    logic          start, all_diff;
    forever begin
      @(posedge clk or negedge rstn_a);
      if (!rstn_a) begin
        m_edges = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
        m_sticky = '0; m_kf = '0; m_tick = 1'b0; m_vprev = 1'b0; m_pix = 1'b0;
        m_hist.delete();
      end else begin
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = keys_a;
        m_hist.push_back(seen);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        start   = (vs_a == 1'b0) && (m_vprev != 1'b0);
        m_vprev = vs_a;
        m_tick  = start;
        if (start) begin
          m_kf     = m_lvl | m_sticky;
          m_sticky = m_press;
        end else begin
          m_sticky = m_sticky | m_press;
        end
        np = '0;
        for (int k = 0; k < NK; k++) begin
          all_diff = (m_hist.size() == DEB);
          for (int j = 0; j < m_hist.size(); j++)
            if (m_hist[j][k] == m_lvl[k]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[k] = ~m_lvl[k];
            np[k]    = m_lvl[k];
          end
        end
        m_press = np;
        m_edges = m_edges + 1;
        m_pix   = (m_edges % DIV_A) == 0;
      end
    end
  end

  task automatic do_reset_a();
    @(negedge clk);
    rstn_a = 1'b0; keys_a = '0; vs_a = 1'b1;
    repeat (3) @(negedge clk);
    rstn_a = 1'b1;
  endtask

  task automatic do_reset_b();
    @(negedge clk);
    rstn_b = 1'b0; keys_b = '1; vs_b = 1'b1;
    repeat (3) @(negedge clk);
    rstn_b = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn_a = 1'b0; rstn_b = 1'b0; keys_a = 4'b1011; keys_b = 4'b0000; vs_a = 1'b0; vs_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({pix_a, tick_a, lvl_a, prs_a, kf_a} !== '0) begin
        errors++;
        $display("FAIL reset_a outputs got %b expected 0", {pix_a, tick_a, lvl_a, prs_a, kf_a});
      end
      vectors++;
      if ({pix_b, tick_b, lvl_b, prs_b, kf_b} !== '0) begin
        errors++;
        $display("FAIL reset_b outputs got %b expected 0", {pix_b, tick_b, lvl_b, prs_b, kf_b});
      end
    end
  endtask

  task automatic test_divider();
    logic exp;
    do_reset_a();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp = (m_edges % DIV_A) == 0;
      vectors++;
      if (pix_a !== exp) begin
        errors++;
        $display("FAIL divider edge %0d pix_en got %b expected %b", m_edges, pix_a, exp);
      end
    end
  endtask

  task automatic test_debounce();
    logic exp_l, exp_p;
    do_reset_a();
    for (int i = 0; i < 32; i++) begin
      if (m_edges == 9)  keys_a[0] = 1'b1;
      if (m_edges == 19) keys_a[0] = 1'b0;
      @(negedge clk);
      exp_l = (m_edges >= 15) && (m_edges < 25);
      exp_p = (m_edges == 15);
      vectors++;
      if (lvl_a[0] !== exp_l || prs_a[0] !== exp_p) begin
        errors++;
        $display("FAIL debounce edge %0d level/press got %b%b expected %b%b",
                 m_edges, lvl_a[0], prs_a[0], exp_l, exp_p);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_l, exp_p;
    do_reset_a();
    for (int i = 0; i < 30; i++) begin
      if (m_edges == 4)  keys_a[1] = 1'b1;
      if (m_edges == 7)  keys_a[1] = 1'b0;
      if (m_edges == 15) keys_a[1] = 1'b1;
      if (m_edges == 19) keys_a[1] = 1'b0;
      @(negedge clk);
      exp_l = (m_edges >= 21) && (m_edges < 25);
      exp_p = (m_edges == 21);
      vectors++;
      if (lvl_a[1] !== exp_l || prs_a[1] !== exp_p) begin
        errors++;
        $display("FAIL glitch edge %0d level/press got %b%b expected %b%b",
                 m_edges, lvl_a[1], prs_a[1], exp_l, exp_p);
      end
    end
  endtask

  task automatic test_frame_tap();
    logic exp_t, exp_k;
    do_reset_a();
    for (int i = 0; i < 46; i++) begin
      if (m_edges == 2 || m_edges == 30 || m_edges == 40) vs_a = 1'b0;
      if (m_edges == 5 || m_edges == 33 || m_edges == 43) vs_a = 1'b1;
      if (m_edges == 8)  keys_a[2] = 1'b1;
      if (m_edges == 14) keys_a[2] = 1'b0;
      @(negedge clk);
      exp_t = (m_edges == 3) || (m_edges == 31) || (m_edges == 41);
      exp_k = (m_edges >= 31) && (m_edges < 41);
      vectors++;
      if (tick_a !== exp_t || kf_a[2] !== exp_k) begin
        errors++;
        $display("FAIL frame_tap edge %0d tick/key_frame got %b%b expected %b%b",
                 m_edges, tick_a, kf_a[2], exp_t, exp_k);
      end
    end
  endtask

  task automatic test_active_low();
    int presses, ticks;
    do_reset_b();
    keys_b = 4'b1110;
    presses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (prs_b[0]) presses++;
      vectors++;
      if (pix_b !== 1'b1) begin
        errors++;
        $display("FAIL div1 pix_en cycle %0d got %b expected 1", i, pix_b);
      end
    end
    vectors++;
    if (lvl_b !== 4'b0001) begin
      errors++;
      $display("FAIL active_low key_level got %b expected 0001", lvl_b);
    end
    vectors++;
    if (presses != 1) begin
      errors++;
      $display("FAIL active_low press count got %0d expected 1", presses);
    end
    repeat (5) @(negedge clk);
    vs_b = 1'b0;
    ticks = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick_b) ticks++;
    end
    vs_b = 1'b1;
    vectors++;
    if (ticks != 1) begin
      errors++;
      $display("FAIL vsync_hold tick count got %0d expected 1", ticks);
    end
    vectors++;
    if (kf_b !== 4'b0001) begin
      errors++;
      $display("FAIL active_low key_frame got %b expected 0001", kf_b);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_l, exp_p;
    do_reset_a();
    for (int i = 0; i < 8; i++) begin
      if (m_edges == 5) keys_a[3] = 1'b1;
      @(negedge clk);
    end
    rstn_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({pix_a, tick_a, lvl_a, prs_a, kf_a} !== '0) begin
        errors++;
        $display("FAIL reset_mid outputs got %b expected 0", {pix_a, tick_a, lvl_a, prs_a, kf_a});
      end
    end
    rstn_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_l = (m_edges >= DEB + 2);
      exp_p = (m_edges == DEB + 2);
      vectors++;
      if (lvl_a[3] !== exp_l || prs_a[3] !== exp_p) begin
        errors++;
        $display("FAIL reset_mid edge %0d level/press got %b%b expected %b%b",
                 m_edges, lvl_a[3], prs_a[3], exp_l, exp_p);
      end
    end
    keys_a[3] = 1'b0;
  endtask

  task automatic test_random();
    do_reset_a();
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      vectors++;
      if (pix_a !== m_pix) begin
        errors++;
        $display("FAIL random edge %0d pix_en got %b expected %b", m_edges, pix_a, m_pix);
      end
      vectors++;
      if (lvl_a !== m_lvl || prs_a !== m_press) begin
        errors++;
        $display("FAIL random edge %0d level/press got %b/%b expected %b/%b",
                 m_edges, lvl_a, prs_a, m_lvl, m_press);
      end
      vectors++;
      if (tick_a !== m_tick || kf_a !== m_kf) begin
        errors++;
        $display("FAIL random edge %0d tick/key_frame got %b/%b expected %b/%b",
                 m_edges, tick_a, kf_a, m_tick, m_kf);
      end
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 7) == 0) keys_a[k] = ~keys_a[k];
      if ($urandom_range(0, 9) < 2) vs_a = ~vs_a;
    end
  endtask

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    keys_a = '0; keys_b = '1; vs_a = 1'b1; vs_b = 1'b1;
    test_reset();
    test_divider();
    test_debounce();
    test_glitch();
    test_frame_tap();
    test_active_low();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
